// File: rtl/param_blockram_pkg.sv
// Shared types and default sizes for param_blockram.
package param_blockram_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 8;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

endpackage

// File: rtl/param_blockram_if.sv
// User-side request/response bundle for param_blockram.
interface param_blockram_if
  import param_blockram_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
);

  logic              clear_req;
  logic              w_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] data_in;
  logic              r_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready;

  modport master (
    output clear_req, w_en, w_addr, data_in, r_en, r_addr,
    input  data_out, valid_out, ready
  );

  modport slave (
    input  clear_req, w_en, w_addr, data_in, r_en, r_addr,
    output data_out, valid_out, ready
  );

endinterface

// File: rtl/param_blockram_core.sv
// Bare simple dual-port array, one write port and one registered read port, no reset,
// written in the shape yosys infers as iCE40 EBR.
module param_blockram_core #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/param_blockram.sv
// Block RAM with clear sequencer, read-valid tracking and write-first forwarding.
// Optional output register stage: define PARAM_BLOCKRAM_OUTREG_EN.
module param_blockram
  import param_blockram_pkg::*;
#(
  parameter int unsigned       DATA_W     = DATA_W_DEF,
  parameter int unsigned       ADDR_W     = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input logic             clk,
  input logic             rst_n,
  param_blockram_if.slave bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic [ADDR_W-1:0] w_clr_addr_nxt;
  logic              r_ready;
  logic              r_valid;
  logic              r_data_ok;
  logic              r_fwd_hit;
  logic [DATA_W-1:0] r_fwd_data;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_core_we;
  logic [ADDR_W-1:0] w_core_waddr;
  logic [DATA_W-1:0] w_core_wdata;
  logic [DATA_W-1:0] w_core_rdata;
  logic [DATA_W-1:0] w_rd_data;

  // Next state, clear counter and write-port mux (sweep owns the port while clearing).
  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_wr_acc       = 1'b0;
    w_rd_acc       = 1'b0;
    w_core_we      = 1'b0;
    w_core_waddr   = bus.w_addr;
    w_core_wdata   = bus.data_in;
    case (r_state)
      CLEAR: begin
        w_core_we      = 1'b1;
        w_core_waddr   = r_clr_addr;
        w_core_wdata   = INIT_VALUE;
        w_clr_addr_nxt = r_clr_addr + ADDR_W'(1);
        if (&r_clr_addr) w_state_nxt = READY;
      end
      READY: begin
        w_wr_acc  = bus.w_en;
        w_rd_acc  = bus.r_en;
        w_core_we = bus.w_en;
        if (bus.clear_req) begin
          w_state_nxt    = CLEAR;
          w_clr_addr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt    = CLEAR;
        w_clr_addr_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_data_ok  <= 1'b0;
      r_fwd_hit  <= 1'b0;
      r_fwd_data <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
      r_ready    <= (w_state_nxt == READY);
      r_valid    <= w_rd_acc;
      if (w_rd_acc) begin
        r_data_ok  <= 1'b1;
        r_fwd_hit  <= w_wr_acc && (bus.w_addr == bus.r_addr);
        r_fwd_data <= bus.data_in;
      end
    end
  end

  param_blockram_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .i_clk   (clk),
    .i_we    (w_core_we),
    .i_waddr (w_core_waddr),
    .i_wdata (w_core_wdata),
    .i_re    (w_rd_acc),
    .i_raddr (bus.r_addr),
    .o_rdata (w_core_rdata)
  );

  // Core read register has no reset, so r_data_ok masks it to zero until the first read.
  assign w_rd_data = !r_data_ok ? '0 : (r_fwd_hit ? r_fwd_data : w_core_rdata);

`ifdef PARAM_BLOCKRAM_OUTREG_EN
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_valid;
      if (r_valid) r_out_data <= w_rd_data;
    end
  end

  assign bus.data_out  = r_out_data;
  assign bus.valid_out = r_out_valid;
`else
  assign bus.data_out  = w_rd_data;
  assign bus.valid_out = r_valid;
`endif

  assign bus.ready = r_ready;

endmodule

// File: tb/tb_param_blockram.sv
// Scoreboard bench for param_blockram: expected read data queued at issue, compared on valid_out.
module tb_param_blockram;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  param_blockram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  param_blockram #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .INIT_VALUE (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.valid_out) begin
      if (exp_q.size() == 0) check("valid_unexpected", 32'(bus.valid_out), 32'd0);
      else                   check("rd_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.clear_req = 1'b0;
    bus.w_en      = 1'b0;
    bus.w_addr    = '0;
    bus.data_in   = '0;
    bus.r_en      = 1'b0;
    bus.r_addr    = '0;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < int'(DEPTH); i++) mdl[i] = '0;
  endtask

  // One user cycle; expected read data (write-first when addresses match) is queued here.
  task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic re, input logic [AW-1:0] ra);
    bus.w_en    = we;
    bus.w_addr  = wa;
    bus.data_in = wd;
    bus.r_en    = re;
    bus.r_addr  = ra;
    if (re) exp_q.push_back((we && wa == ra) ? wd : mdl[ra]);
    tick();
    if (we) mdl[wa] = wd;
    idle_in();
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // Counts edges until ready rises; noise drives user strobes that must be ignored.
  task automatic wait_ready(input string tag, input int exp_cycles, input logic noise);
    int n = 0;
    while (!bus.ready && n < 1000) begin
      if (noise) begin
        bus.w_en    = 1'b1;
        bus.r_en    = 1'b1;
        bus.w_addr  = AW'($urandom);
        bus.r_addr  = AW'($urandom);
        bus.data_in = DW'($urandom);
      end
      tick();
      n++;
    end
    idle_in();
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle_in();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    rst_n = 1'b1;
    mdl_clear();
    wait_ready("ready_after_reset", 256, 1'b0);

    // Cleared contents at low, next and top addresses.
    op(1'b0, '0, '0, 1'b1, 8'h00); tick();
    op(1'b0, '0, '0, 1'b1, 8'h01); tick();
    op(1'b0, '0, '0, 1'b1, 8'hFF);
    drain("drain_init");

    op(1'b1, 8'h10, 16'hBEEF, 1'b0, '0);
    op(1'b0, '0, '0, 1'b1, 8'h10);
    drain("drain_beef");

    op(1'b1, 8'h20, 16'h1234, 1'b1, 8'h20);
    drain("drain_fwd");
    op(1'b1, 8'h20, 16'h1234, 1'b1, 8'h21);
    drain("drain_nofwd");

    for (int i = 0; i < int'(DEPTH); i++) op(1'b1, AW'(i), DW'(i + 1), 1'b0, '0);
    op(1'b0, '0, '0, 1'b1, 8'h80);
    op(1'b0, '0, '0, 1'b1, 8'hFF);
    drain("drain_fill");

    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    check("ready_drop_on_clear", 32'(bus.ready), 32'd0);
    wait_ready("clear_sweep_len", 256, 1'b1);
    mdl_clear();
    for (int i = 0; i < int'(DEPTH); i++) op(1'b0, '0, '0, 1'b1, AW'(i));
    drain("drain_after_clear");

    // Back-to-back burst.
    for (int i = 0; i < 8; i++) op(1'b1, AW'(i), DW'(16'hA0 + i), 1'b0, '0);
    for (int i = 0; i < 8; i++) op(1'b0, '0, '0, 1'b1, AW'(i));
    drain("drain_burst");

    // Reset in the middle of back-to-back reads.
    for (int i = 0; i < 3; i++) op(1'b0, '0, '0, 1'b1, AW'(i));
    bus.r_en   = 1'b1;
    bus.r_addr = 8'h03;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rst_reads_valid", 32'(bus.valid_out), 32'd0);
    check("rst_reads_data", 32'(bus.data_out), 32'd0);
    check("rst_reads_ready", 32'(bus.ready), 32'd0);
    idle_in();
    tick();
    rst_n = 1'b1;
    mdl_clear();
    wait_ready("sweep_after_rst_reads", 256, 1'b0);
    for (int i = 0; i < 8; i++) op(1'b0, '0, '0, 1'b1, AW'(i));
    drain("drain_after_rst_reads");

    // Reset at sweep cycle 100; data_out must hold through the sweep until then.
    op(1'b1, 8'h05, 16'h0077, 1'b0, '0);
    op(1'b0, '0, '0, 1'b1, 8'h05);
    drain("drain_hold_setup");
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.w_en = 1'b1;
      bus.r_en = 1'b1;
      tick();
    end
    idle_in();
    check("hold_in_clear", 32'(bus.data_out), 32'h0077);
    rst_n = 1'b0;
    #1;
    check("rst_sweep_valid", 32'(bus.valid_out), 32'd0);
    check("rst_sweep_data", 32'(bus.data_out), 32'd0);
    check("rst_sweep_ready", 32'(bus.ready), 32'd0);
    tick();
    rst_n = 1'b1;
    mdl_clear();
    wait_ready("sweep_after_rst_mid", 256, 1'b0);
    op(1'b0, '0, '0, 1'b1, 8'h05);
    op(1'b0, '0, '0, 1'b1, 8'hFF);
    drain("drain_final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_blockram.md
# param_blockram

Parametrised simple dual-port block RAM with a hardware clear sequencer, read-valid tracking and read-during-write forwarding. Used wherever a design needs a scratch or lookup memory on the iCEBreaker with a known power-on and reset state. The array maps onto iCE40 EBR. Reset and re-clear are done by a sequencer that sweeps the array, because EBR contents cannot be reset directly.

## Interface
- DATA_W, default 16: word width in bits.
- ADDR_W, default 8: address width; DEPTH = 2**ADDR_W words.
- INIT_VALUE, default 0: word written to every location during a clear sweep (DATA_W bits).
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low; one clock, reset asynchronous active-low.
- clear_req  in  1  pulse or level; starts a new clear sweep when the block is idle.
- w_en  in  1  write strobe.
- w_addr  in  ADDR_W  write address.
- data_in  in  DATA_W  write data.
- r_en  in  1  read strobe.
- r_addr  in  ADDR_W  read address.
- data_out  out  DATA_W  read data, held until the next accepted read.
- valid_out  out  1  one-cycle pulse marking new data_out.
- ready  out  1  high when user reads and writes are accepted (state READY).

## Operation
- FSM states: CLEAR, READY.
- Reset state is CLEAR with clr_addr = 0.
- Reset values: data_out = 0, valid_out = 0, ready = 0.
- CLEAR:
  - Each cycle writes INIT_VALUE to clr_addr, then clr_addr increments.
  - After the write to DEPTH-1, the FSM goes to READY.
  - w_en and r_en are ignored: no write, no valid_out, data_out holds.
  - clear_req is ignored.
- READY, clear_req = 1:
  - The FSM goes to CLEAR with clr_addr = 0.
  - A w_en or r_en in that same cycle is still serviced (READY rules apply).
- READY, w_en = 1: memory[w_addr] <= data_in.
- READY, r_en = 1:
  - data_out takes memory[r_addr].
  - valid_out pulses once per accepted read.
- Same-cycle w_en and r_en with w_addr == r_addr: data_out returns data_in (write-first, forwarded). Different addresses: old contents of r_addr.
- Addresses are ADDR_W wide, so every address is in range; no wrap logic is needed.
- rst_n asserted mid-sweep or mid-read:
  - Immediately forces CLEAR, clr_addr = 0, valid_out = 0, data_out = 0.
  - Any pipelined read is discarded.

## Timing
- Reset deasserted before edge 0: edges 0..DEPTH-1 perform the clear writes; ready = 1 after edge DEPTH-1 (DEPTH cycles).
- clear_req sampled high in READY at edge k: ready = 0 after edge k; ready = 1 again after edge k+DEPTH.
- Read latency, macro off: r_en at edge k gives data_out and valid_out = 1 after edge k; valid_out drops after edge k+1 unless another read is accepted.
- Back-to-back reads give one valid_out pulse per cycle. Full throughput: one read and one write per cycle.
- Write visible to a read issued at a later edge; same-edge read sees it via forwarding.

## Configuration
- PARAM_BLOCKRAM_OUTREG_EN defined:
  - Adds an output register stage after the EBR read port.
  - Read latency becomes 2 cycles; data_out and valid_out move together.
  - Forwarded data is delayed identically.
  - Reset clears both the stage and its valid bit.
- PARAM_BLOCKRAM_OUTREG_EN undefined: 1-cycle latency as above.

## Structure
- Shared package param_blockram_pkg:
  - State enum (CLEAR, READY).
  - Default parameter constants (DATA_W_DEF = 16, ADDR_W_DEF = 8).
- Sub-module param_blockram_core:
  - Bare inferable EBR array: one write port, one registered read port, no reset.
  - Chosen so yosys maps it cleanly.
- param_blockram (top) contains:
  - FSM and clear address counter.
  - Write mux (clear vs user).
  - Forwarding compare.
  - Valid tracking.
  - Optional output stage.

## Test plan
- Reset, then wait for ready; read addresses 0, 1, 255 -> data_out = 0x0000 each, valid_out one-cycle pulse each; ready rises exactly 256 cycles after reset release.
- Write 0xBEEF to 0x10, read 0x10 on the next cycle -> data_out = 0xBEEF after 1 cycle (2 with PARAM_BLOCKRAM_OUTREG_EN).
- Same-cycle write 0x1234 and read, both at 0x20 (previously 0x0000) -> data_out = 0x1234. Repeat with read at 0x21 -> data_out = 0x0000.
- Fill 0x00..0xFF with addr+1; pulse clear_req; assert w_en and r_en during the sweep -> no valid_out, ready low 256 cycles; afterwards every location reads 0x0000.
- Assert rst_n low at sweep cycle 100 and mid back-to-back reads -> valid_out = 0 and data_out = 0 immediately; full 256-cycle sweep restarts from address 0.
- Reads on 8 consecutive cycles at addresses 0..7 holding 0xA0..0xA7 -> 8 consecutive valid_out pulses, data_out in order 0xA0..0xA7.
